collision_scheduler: RTL and testbench

Time-multiplexed collision controller. Once per frame it runs a single shared box-overlap comparator over all stairs, then the monster, then the bullet. It publishes registered stair-landing, death, monster-beaten and bullet-hit results to the game-state logic. It replaces per-object parallel comparators. The block sits between the doodler, stair, monster and bullet position generators and the game FSM.

---
 rtl/collision_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_collision_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scheduler.sv
// Time-multiplexed collision controller: one scan per frame over all stairs, then the
// monster, then the bullet, through a single shared box-overlap comparator.
module collision_scheduler #(
   parameter int unsigned N_STAIR       = 14,
   parameter int unsigned IDX_W         = 4,
   parameter int unsigned MON_SIZE      = 39,
   parameter int unsigned STAIR_TOL     = 5,
   parameter int unsigned FALL_STEP_MAX = 50,
   parameter int unsigned BEAT_STEP_MAX = 100
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    frame_clk,
   input  logic [9:0]              BallX,
   input  logic [9:0]              BallY,
   input  logic [9:0]              BallS,
   input  logic [9:0]              Ball_y_step,
   input  logic [N_STAIR-1:0][9:0] StairX,
   input  logic [N_STAIR-1:0][9:0] StairY,
   input  logic [9:0]              StairS,
   input  logic [9:0]              MonsterX,
   input  logic [9:0]              MonsterY,
   input  logic                    appear,
   input  logic [9:0]              BulletX,
   input  logic [9:0]              BulletY,
   input  logic [9:0]              BulletS,
   input  logic                    fly,
   output logic                    busy,
   output logic                    result_valid,
   output logic                    collision,
   output logic [IDX_W-1:0]        stair_idx,
   output logic                    dead,
   output logic                    beat_monster,
   output logic                    hit,
   output logic                    overrun
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_STAIR   = 3'd1;
   localparam logic [2:0] S_MONSTER = 3'd2;
   localparam logic [2:0] S_BULLET  = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [9:0]       MonSize  = 10'(MON_SIZE);
   localparam logic [9:0]       StairTol = 10'(STAIR_TOL);
   localparam logic [9:0]       FallMax  = 10'(FALL_STEP_MAX);
   localparam logic [9:0]       BeatMax  = 10'(BEAT_STEP_MAX);
   localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(N_STAIR - 1);

   logic [2:0]       state_q, state_d;
   logic             fc_q;
   logic             pending_q, pending_d;
   logic             overrun_q, overrun_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             found_q, found_d;
   logic [IDX_W-1:0] sidx_nxt_q, sidx_nxt_d;
   logic             beat_nxt_q, beat_nxt_d;
   logic             dead_nxt_q, dead_nxt_d;
   logic             collision_q, dead_q, beat_q, hit_q;
   logic [IDX_W-1:0] stair_idx_q;
   logic             latch, load_out;

   // Frame snapshot
   logic [9:0]              bx_q, by_q, bs_q, step_q;
   logic [N_STAIR-1:0][9:0] sx_q, sy_q;
   logic [9:0]              ss_q, mx_q, my_q, ux_q, uy_q, us_q;
   logic                    appear_q, fly_q;

   logic fr_edge, busy_w;
   logic [9:0] cur_sx, cur_sy, ball_r, ball_l, foot, st_l, st_r, st_lo, st_hi;
   logic stair_hit;
   logic [9:0] ox, oy, os, o_r, o_l, o_b, o_t, m_r, m_b;
   logic box_qual, box_hit;

   assign fr_edge = frame_clk & ~fc_q;
   assign busy_w  = (state_q != S_IDLE);

   always_comb begin
      cur_sx    = sx_q[idx_q];
      cur_sy    = sy_q[idx_q];
      ball_r    = bx_q + bs_q;
      ball_l    = bx_q - bs_q;
      foot      = by_q + bs_q + step_q;
      st_l      = cur_sx - ss_q;
      st_r      = cur_sx + ss_q;
      st_lo     = cur_sy - StairTol;
      st_hi     = cur_sy + StairTol;
      stair_hit = (step_q < FallMax) && (ball_r >= st_l) && (ball_l <= st_r) &&
                  (st_lo <= foot) && (foot <= st_hi);
   end

   // Shared comparator: the doodler box in MONSTER, the bullet box in BULLET.
   always_comb begin
      if (state_q == S_BULLET) begin
         ox       = ux_q;
         oy       = uy_q;
         os       = us_q;
         box_qual = appear_q & fly_q;
      end else begin
         ox       = bx_q;
         oy       = by_q;
         os       = bs_q;
         box_qual = appear_q;
      end
      o_r     = ox + os;
      o_l     = ox - os;
      o_b     = oy + os;
      o_t     = oy - os;
      m_r     = mx_q + MonSize;
      m_b     = my_q + MonSize;
      box_hit = box_qual && (o_r > mx_q) && (o_l < m_r) && (o_b > my_q) && (o_t < m_b);
   end

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      overrun_d  = overrun_q;
      idx_d      = idx_q;
      found_d    = found_q;
      sidx_nxt_d = sidx_nxt_q;
      beat_nxt_d = beat_nxt_q;
      dead_nxt_d = dead_nxt_q;
      latch      = 1'b0;
      load_out   = 1'b0;

      if (fr_edge && busy_w) begin
         if (pending_q) overrun_d = 1'b1;
         pending_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (fr_edge || pending_q) begin
               latch      = 1'b1;
               idx_d      = '0;
               found_d    = 1'b0;
               sidx_nxt_d = '0;
               state_d    = S_STAIR;
               // An edge arriving while a queued frame is consumed stays queued.
               pending_d  = pending_q & fr_edge;
            end
         end
         S_STAIR: begin
            if (stair_hit && !found_q) begin
               found_d    = 1'b1;
               sidx_nxt_d = idx_q;
            end
            if (idx_q == LastIdx) state_d = S_MONSTER;
            else                  idx_d   = idx_q + IDX_W'(1);
         end
         S_MONSTER: begin
            beat_nxt_d = box_hit & (step_q < BeatMax);
            dead_nxt_d = box_hit & ~(step_q < BeatMax);
            state_d    = S_BULLET;
         end
         S_BULLET: begin
            load_out = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            // A frame queued earlier in the scan restarts straight from DONE.
            if (pending_q) begin
               latch      = 1'b1;
               idx_d      = '0;
               found_d    = 1'b0;
               sidx_nxt_d = '0;
               state_d    = S_STAIR;
               pending_d  = fr_edge;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         fc_q        <= 1'b0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
         idx_q       <= '0;
         found_q     <= 1'b0;
         sidx_nxt_q  <= '0;
         beat_nxt_q  <= 1'b0;
         dead_nxt_q  <= 1'b0;
         collision_q <= 1'b0;
         stair_idx_q <= '0;
         dead_q      <= 1'b0;
         beat_q      <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         fc_q       <= frame_clk;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         idx_q      <= idx_d;
         found_q    <= found_d;
         sidx_nxt_q <= sidx_nxt_d;
         beat_nxt_q <= beat_nxt_d;
         dead_nxt_q <= dead_nxt_d;
         if (load_out) begin
            collision_q <= found_q;
            stair_idx_q <= sidx_nxt_q;
            dead_q      <= dead_nxt_q;
            beat_q      <= beat_nxt_q;
            hit_q       <= box_hit;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (latch) begin
         bx_q     <= BallX;
         by_q     <= BallY;
         bs_q     <= BallS;
         step_q   <= Ball_y_step;
         sx_q     <= StairX;
         sy_q     <= StairY;
         ss_q     <= StairS;
         mx_q     <= MonsterX;
         my_q     <= MonsterY;
         appear_q <= appear;
         ux_q     <= BulletX;
         uy_q     <= BulletY;
         us_q     <= BulletS;
         fly_q    <= fly;
      end
   end

   assign busy         = busy_w;
   assign result_valid = (state_q == S_DONE);
   assign collision    = collision_q;
   assign stair_idx    = stair_idx_q;
   assign dead         = dead_q;
   assign beat_monster = beat_q;
   assign hit          = hit_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: directed vector table, multi-frame sequences and
// randomized frames against a rule-level reference model.
module tb_collision_scheduler;

   localparam int N = 14;

   logic             clk = 1'b0;
   logic             rst;
   logic             frame_clk;
   logic [9:0]       ball_x, ball_y, ball_s, step;
   logic [N-1:0][9:0] stair_x, stair_y;
   logic [9:0]       stair_s, mon_x, mon_y, bul_x, bul_y, bul_s;
   logic             appear, fly;
   logic             busy, result_valid, collision, dead, beat_monster, hit, overrun;
   logic [3:0]       stair_idx;

   int checks = 0;
   int failures = 0;

   collision_scheduler dut (
      .Clk          (clk),
      .Reset        (rst),
      .frame_clk    (frame_clk),
      .BallX        (ball_x),
      .BallY        (ball_y),
      .BallS        (ball_s),
      .Ball_y_step  (step),
      .StairX       (stair_x),
      .StairY       (stair_y),
      .StairS       (stair_s),
      .MonsterX     (mon_x),
      .MonsterY     (mon_y),
      .appear       (appear),
      .BulletX      (bul_x),
      .BulletY      (bul_y),
      .BulletS      (bul_s),
      .fly          (fly),
      .busy         (busy),
      .result_valid (result_valid),
      .collision    (collision),
      .stair_idx    (stair_idx),
      .dead         (dead),
      .beat_monster (beat_monster),
      .hit          (hit),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int bx, by, bs, st;
      int sa, sxa, ya, sb, yb;
      int mx, my, app;
      int ux, uy, us, fl;
      int col, idx, dead, beat, hit;
   } vec_t;

   vec_t tbl[22];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic bit box_ovl(input logic [9:0] ox, oy, os);
      logic [9:0] r, l, b, t, mr, mb;
      r  = ox + os;
      l  = ox - os;
      b  = oy + os;
      t  = oy - os;
      mr = mon_x + 10'd39;
      mb = mon_y + 10'd39;
      return (r > mon_x) && (l < mr) && (b > mon_y) && (t < mb);
   endfunction

   task automatic ref_model(output int e_col, e_idx, e_dead, e_beat, e_hit);
      logic [9:0] br, bl, foot, l, r, lo, hi;
      bit m;
      e_col = 0;
      e_idx = 0;
      br    = ball_x + ball_s;
      bl    = ball_x - ball_s;
      foot  = ball_y + ball_s + step;
      for (int i = N - 1; i >= 0; i--) begin
         l  = stair_x[i] - stair_s;
         r  = stair_x[i] + stair_s;
         lo = stair_y[i] - 10'd5;
         hi = stair_y[i] + 10'd5;
         if (step < 10'd50 && br >= l && bl <= r && lo <= foot && foot <= hi) begin
            e_col = 1;
            e_idx = i;
         end
      end
      m      = appear && box_ovl(ball_x, ball_y, ball_s);
      e_beat = (m && step < 10'd100) ? 1 : 0;
      e_dead = (m && e_beat == 0) ? 1 : 0;
      e_hit  = (appear && fly && box_ovl(bul_x, bul_y, bul_s)) ? 1 : 0;
   endtask

   task automatic apply_vec(input vec_t v);
      for (int i = 0; i < N; i++) begin
         stair_x[i] = 10'd100;
         stair_y[i] = 10'd500;
      end
      stair_x[v.sa] = 10'(v.sxa);
      stair_y[v.sa] = 10'(v.ya);
      stair_y[v.sb] = 10'(v.yb);
      stair_s = 10'd20;
      ball_x  = 10'(v.bx);
      ball_y  = 10'(v.by);
      ball_s  = 10'(v.bs);
      step    = 10'(v.st);
      mon_x   = 10'(v.mx);
      mon_y   = 10'(v.my);
      appear  = v.app[0];
      bul_x   = 10'(v.ux);
      bul_y   = 10'(v.uy);
      bul_s   = 10'(v.us);
      fly     = v.fl[0];
   endtask

   // Inputs are scrambled right after the latch cycle; results must reflect the snapshot.
   task automatic scramble();
      ball_x = 10'($urandom);
      ball_y = 10'($urandom);
      step   = 10'($urandom);
      for (int i = 0; i < N; i++) stair_y[i] = 10'($urandom);
      mon_x  = 10'($urandom);
      appear = ~appear;
      fly    = ~fly;
   endtask

   task automatic run_frame(input string tag, input int e_col, e_idx, e_dead, e_beat, e_hit);
      int n;
      bit got, busy_bad;
      n        = 0;
      got      = 0;
      busy_bad = (busy !== 1'b0);
      frame_clk = 1'b1;
      while (!got && n < 40) begin
         tick();
         n++;
         if (n == 1) begin
            frame_clk = 1'b0;
            scramble();
         end
         if (busy !== 1'b1) busy_bad = 1;
         if (result_valid === 1'b1) got = 1;
      end
      chk({tag, "_latency"}, n, 17);
      chk({tag, "_busy"}, busy_bad, 0);
      chk({tag, "_col"}, collision, e_col);
      chk({tag, "_idx"}, stair_idx, e_idx);
      chk({tag, "_dead"}, dead, e_dead);
      chk({tag, "_beat"}, beat_monster, e_beat);
      chk({tag, "_hit"}, hit, e_hit);
      tick();
      chk({tag, "_pulse"}, result_valid, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int e_col, e_idx, e_dead, e_beat, e_hit;
      int n, first, second, pulses;
      bit wide;

      //          bx   by   bs st  sa sxa  ya   sb yb   mx   my  ap ux   uy   us fl  c i  d b h
      tbl[0]  = '{100, 200, 8, 3,  5, 100, 211, 5, 211, 0,   0,   0, 0,   0,   0, 0, 1, 5, 0, 0, 0};
      tbl[1]  = '{100, 200, 8, 3,  3, 100, 211, 9, 211, 0,   0,   0, 0,   0,   0, 0, 1, 3, 0, 0, 0};
      tbl[2]  = '{100, 200, 8, 60, 3, 100, 268, 9, 268, 0,   0,   0, 0,   0,   0, 0, 0, 0, 0, 0, 0};
      tbl[3]  = '{100, 200, 8, 49, 3, 100, 257, 9, 257, 0,   0,   0, 0,   0,   0, 0, 1, 3, 0, 0, 0};
      tbl[4]  = '{100, 200, 8, 50, 3, 100, 258, 9, 258, 0,   0,   0, 0,   0,   0, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{100, 200, 8, 3,  7, 100, 216, 7, 216, 0,   0,   0, 0,   0,   0, 0, 1, 7, 0, 0, 0};
      tbl[6]  = '{100, 200, 8, 3,  7, 100, 217, 7, 217, 0,   0,   0, 0,   0,   0, 0, 0, 0, 0, 0, 0};
      tbl[7]  = '{100, 200, 8, 3,  7, 100, 206, 7, 206, 0,   0,   0, 0,   0,   0, 0, 1, 7, 0, 0, 0};
      tbl[8]  = '{100, 200, 8, 3,  7, 100, 205, 7, 205, 0,   0,   0, 0,   0,   0, 0, 0, 0, 0, 0, 0};
      tbl[9]  = '{72,  200, 8, 3,  4, 100, 211, 4, 211, 0,   0,   0, 0,   0,   0, 0, 1, 4, 0, 0, 0};
      tbl[10] = '{71,  200, 8, 3,  4, 100, 211, 4, 211, 0,   0,   0, 0,   0,   0, 0, 0, 0, 0, 0, 0};
      tbl[11] = '{10,  200, 8, 3,  2, 5,   211, 2, 211, 0,   0,   0, 0,   0,   0, 0, 0, 0, 0, 0, 0};
      tbl[12] = '{110, 200, 8, 20, 0, 100, 500, 0, 500, 100, 190, 1, 0,   0,   0, 0, 0, 0, 0, 1, 0};
      tbl[13] = '{110, 200, 8, 120, 0, 100, 500, 0, 500, 100, 190, 1, 0,  0,   0, 0, 0, 0, 1, 0, 0};
      tbl[14] = '{110, 200, 8, 99, 0, 100, 500, 0, 500, 100, 190, 1, 0,   0,   0, 0, 0, 0, 0, 1, 0};
      tbl[15] = '{110, 200, 8, 100, 0, 100, 500, 0, 500, 100, 190, 1, 0,  0,   0, 0, 0, 0, 1, 0, 0};
      tbl[16] = '{110, 200, 8, 20, 0, 100, 500, 0, 500, 100, 190, 0, 0,   0,   0, 0, 0, 0, 0, 0, 0};
      tbl[17] = '{110, 200, 8, 20, 0, 100, 500, 0, 500, 100, 190, 1, 120, 210, 2, 1, 0, 0, 0, 1, 1};
      tbl[18] = '{110, 200, 8, 20, 0, 100, 500, 0, 500, 100, 190, 1, 120, 210, 2, 0, 0, 0, 0, 1, 0};
      tbl[19] = '{92,  200, 8, 20, 0, 100, 500, 0, 500, 100, 190, 1, 0,   0,   0, 0, 0, 0, 0, 0, 0};
      tbl[20] = '{93,  200, 8, 20, 0, 100, 500, 0, 500, 100, 190, 1, 0,   0,   0, 0, 0, 0, 0, 1, 0};
      tbl[21] = '{110, 237, 8, 20, 0, 100, 500, 0, 500, 100, 190, 1, 120, 210, 2, 0, 0, 0, 0, 0, 0};

      // Reset held with frame_clk toggling
      apply_vec(tbl[0]);
      rst       = 1'b1;
      frame_clk = 1'b0;
      for (int i = 0; i < 3; i++) begin
         frame_clk = ~frame_clk;
         tick();
         chk($sformatf("reset_busy%0d", i), busy, 0);
         chk($sformatf("reset_rv%0d", i), result_valid, 0);
      end
      chk("reset_outs", {collision, stair_idx, dead, beat_monster, hit, overrun}, 0);
      frame_clk = 1'b0;
      rst       = 1'b0;
      tick();
      tick();

      for (int i = 0; i < 22; i++) begin
         apply_vec(tbl[i]);
         run_frame($sformatf("vec%0d", i), tbl[i].col, tbl[i].idx, tbl[i].dead,
                   tbl[i].beat, tbl[i].hit);
      end
      chk("no_overrun_single", overrun, 0);

      // Two edges four cycles apart
      apply_vec(tbl[0]);
      n = 0; first = 0; second = 0;
      frame_clk = 1'b1;
      while (second == 0 && n < 60) begin
         tick();
         n++;
         if (n == 1) frame_clk = 1'b0;
         if (n == 4) frame_clk = 1'b1;
         if (n == 5) frame_clk = 1'b0;
         if (result_valid === 1'b1) begin
            if (first == 0) first = n;
            else second = n;
         end
      end
      chk("b2b_first", first, 17);
      chk("b2b_spacing", second - first, 17);
      chk("b2b_overrun", overrun, 0);
      chk("b2b_col", collision, 1);
      chk("b2b_idx", stair_idx, 5);
      tick();
      tick();

      // Third edge inside the same scan
      frame_clk = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 1 || k == 5 || k == 9) frame_clk = 1'b0;
         if (k == 4 || k == 8) frame_clk = 1'b1;
      end
      chk("ovr_set", overrun, 1);
      chk("ovr_idle", busy, 0);
      apply_vec(tbl[17]);
      run_frame("sticky", 0, 0, 0, 1, 1);
      chk("ovr_sticky", overrun, 1);

      // Reset mid-scan
      frame_clk = 1'b1;
      tick();
      frame_clk = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      tick();
      chk("midrst_busy", busy, 0);
      rst    = 1'b0;
      pulses = 0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (result_valid === 1'b1) pulses++;
      end
      chk("midrst_pulses", pulses, 0);
      chk("midrst_overrun", overrun, 0);
      chk("midrst_outs", {collision, stair_idx, dead, beat_monster, hit}, 0);

      for (int k = 0; k < 30; k++) begin
         wide    = (k % 6 == 5);
         ball_x  = wide ? 10'($urandom) : 10'($urandom_range(60, 160));
         ball_y  = wide ? 10'($urandom) : 10'($urandom_range(150, 250));
         ball_s  = wide ? 10'($urandom) : 10'($urandom_range(0, 15));
         step    = wide ? 10'($urandom) : 10'($urandom_range(0, 120));
         stair_s = wide ? 10'($urandom) : 10'($urandom_range(0, 30));
         for (int i = 0; i < N; i++) begin
            stair_x[i] = wide ? 10'($urandom) : 10'($urandom_range(60, 160));
            if ($urandom_range(0, 2) == 0)
               stair_y[i] = 10'(ball_y + ball_s + step) + 10'($urandom_range(0, 12)) - 10'd6;
            else
               stair_y[i] = 10'($urandom);
         end
         mon_x  = wide ? 10'($urandom) : 10'($urandom_range(60, 160));
         mon_y  = wide ? 10'($urandom) : 10'($urandom_range(150, 250));
         appear = 1'($urandom_range(0, 1));
         bul_x  = wide ? 10'($urandom) : 10'($urandom_range(60, 200));
         bul_y  = wide ? 10'($urandom) : 10'($urandom_range(150, 280));
         bul_s  = 10'($urandom_range(0, 8));
         fly    = 1'($urandom_range(0, 1));
         ref_model(e_col, e_idx, e_dead, e_beat, e_hit);
         run_frame($sformatf("rnd%0d", k), e_col, e_idx, e_dead, e_beat, e_hit);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
